// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift/rotate unit.
package shift_pkg;

  localparam int unsigned OP_W    = 2;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ASL = 2'b00,
    OP_LSR = 2'b01,
    OP_ROL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/result bundle between a requester and seq_shift_unit.
interface seq_shift_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] din;
  logic             cin;
  logic [CNT_W-1:0] count;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             cout;
  logic             n;
  logic             z;

  modport master (
    output start, op, din, cin, count, flush,
    input  busy, done, dout, cout, n, z
  );

  modport slave (
    input  start, op, din, cin, count, flush,
    output busy, done, dout, cout, n, z
  );

endinterface

// File: rtl/shift_step.sv
// One single-bit shift/rotate step on {c, acc}.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic             c_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             c_o
);

  // Rotates go through carry, so they act on a WIDTH+1 bit ring.
  always_comb begin
    acc_o = acc_i;
    c_o   = c_i;
    case (op_i)
      OP_ASL: begin
        acc_o = {acc_i[WIDTH-2:0], 1'b0};
        c_o   = acc_i[WIDTH-1];
      end
      OP_LSR: begin
        acc_o = {1'b0, acc_i[WIDTH-1:1]};
        c_o   = acc_i[0];
      end
      OP_ROL: begin
        acc_o = {acc_i[WIDTH-2:0], c_i};
        c_o   = acc_i[WIDTH-1];
      end
      OP_ROR: begin
        acc_o = {c_i, acc_i[WIDTH-1:1]};
        c_o   = acc_i[0];
      end
      default: begin
        acc_o = acc_i;
        c_o   = c_i;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Iterative shift/rotate unit: one bit per clock behind a start/done handshake.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  seq_shift_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_acc;
  logic             step_c;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .c_i   (c_q),
    .op_i  (op_q),
    .acc_o (step_acc),
    .c_o   (step_c)
  );

  // State and working registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      c_q     <= 1'b0;
      op_q    <= OP_ASL;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath; flush overrides everything and freezes the partial result.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    c_d     = c_q;
    op_d    = op_q;
    rem_d   = rem_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d   = bus.din;
          c_d     = bus.cin;
          op_d    = op_e'(bus.op);
          rem_d   = bus.count;
          state_d = (bus.count != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        acc_d = step_acc;
        c_d   = step_c;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.flush) begin
      state_d = ST_IDLE;
      acc_d   = acc_q;
      c_d     = c_q;
      op_d    = op_q;
      rem_d   = '0;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Results are the working registers themselves; flags decode the result.
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = acc_q;
  assign bus.cout = c_q;
  assign bus.n    = acc_q[WIDTH-1];
  assign bus.z    = (acc_q == '0);

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
Parametrised, iterative shift/rotate unit for the cpu6502 ALU path. Generalises the single-bit accumulator shifts (ASL/LSR/ROL/ROR) to any data width and a multi-bit shift count, executing one bit per clock behind a start/done handshake. Produces 6502-style result flags N, Z, C. Intended for the extended-ALU datapath and for reuse in wider (16-bit) address arithmetic.

Parameters:
WIDTH, 8, data width in bits (>= 2)
CNT_W, 4, shift-count width; counts 0 .. 2^CNT_W-1 accepted, may exceed WIDTH

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset; clears all state immediately
start  in  1  request; sampled only when busy=0
op  in  2  00 ASL, 01 LSR, 10 ROL (through carry), 11 ROR (through carry)
din  in  WIDTH  operand, sampled with start
cin  in  1  carry in, sampled with start
count  in  CNT_W  number of single-bit steps, sampled with start
flush  in  1  synchronous abort, highest priority after reset
busy  out  1  high from accepted start until done cycle (inclusive)
done  out  1  one-cycle pulse, result valid
dout  out  WIDTH  result register
cout  out  1  carry out (last bit shifted out / rotated into C)
n  out  1  dout[WIDTH-1]
z  out  1  dout == 0

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, done=0, dout=0, cout=0, n=0, z=1, remaining=0.
- States: IDLE, SHIFT, DONE; 2-bit encoding.
- IDLE: start=1 at edge E0 -> load acc<=din, c<=cin, op_r<=op, remaining<=count; next SHIFT if count!=0, else DONE.
- SHIFT: per edge, one step on {c, acc}; remaining<=remaining-1; when remaining==1 at the edge -> DONE.
- Step rules: ASL acc<={acc[W-2:0],0}, c<=acc[W-1]; LSR acc<={0,acc[W-1:1]}, c<=acc[0]; ROL acc<={acc[W-2:0],c}, c<=acc[W-1]; ROR acc<={c,acc[W-1:1]}, c<=acc[0].
- DONE: done=1 for exactly one cycle, busy=1; next edge -> IDLE.
- Latency: done high in the cycle following edge E_max(count,... ) i.e. count=0 -> after E0; count=k>=1 -> after E_k. Busy high from after E0 through the done cycle.
- dout/cout/n/z are the working registers; they change during SHIFT and hold after done until next accepted start.
- start while busy=1: ignored, no effect on operation in flight; not queued.
- start in the DONE cycle: ignored (busy=1); earliest back-to-back start is the cycle after done.
- count > WIDTH: continues stepping; ASL/LSR saturate to 0 with c=0; ROL/ROR have period WIDTH+1.
- flush=1 at an edge: state<=IDLE, busy<=0, done<=0; dout/cout keep partial value; no done pulse. flush beats start in the same cycle.
- Reset mid-operation: immediate return to reset values; no done pulse.
- n, z combinational from dout; undefined-valued op impossible (2-bit full decode).

Decomposition:
- Package shift_pkg: op encodings OP_ASL/OP_LSR/OP_ROL/OP_ROR, state encodings ST_IDLE/ST_SHIFT/ST_DONE.
- One sub-module: shift_step (combinational, parametrised WIDTH): {c,acc},op -> next {c,acc}; instanced once in the SHIFT datapath.

Test Plan:
- WIDTH=8, ASL din=0xFF cin=0 count=1 -> done after E1, dout=0xFE, cout=1, n=1, z=0.
- ASL din=0xFF count=8 -> dout=0x00, cout=1, z=1, n=0; same with count=9 -> dout=0x00, cout=0, z=1.
- ROR din=0x5A cin=1 count=9 -> dout=0x5A, cout=1 (full rotate restores); ROL din=0x81 cin=0 count=1 -> dout=0x02, cout=1.
- count=0, LSR din=0x3C cin=1 -> done after E0, dout=0x3C, cout=1, busy high one cycle only.
- LSR din=0x80 count=7, pulse start again at E3 with din=0x00 -> ignored; final dout=0x01, cout=0; start the cycle after done accepted.
- ROL count=12 in flight: flush at E4 -> busy=0 next cycle, no done pulse; separate run with reset low at E5 -> dout=0, z=1, busy=0 immediately, no done.
